// File: rtl/tcdm_ecc_err_logger_if.sv
// TCDM request plus ECC decoder result, as seen by the error logger.
// The master drives the signals and the logger (slave) only observes them.
interface tcdm_ecc_err_logger_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 req;
  logic                 gnt;
  logic                 wen;
  logic [AddrWidth-1:0] add;
  logic [6:0]           syndrome;
  logic [1:0]           err;

  modport master (output req, gnt, wen, add, syndrome, err);
  modport slave  (input  req, gnt, wen, add, syndrome, err);
endinterface

// File: rtl/tcdm_ecc_err_logger.sv
// ECC error logger: a two-stage pipeline that counts correctable and uncorrectable
// write errors, captures their addresses, and raises a level interrupt.
module tcdm_ecc_err_logger #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned CeThreshold = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  tcdm_ecc_err_logger_if.slave        bus_i,
  input  logic                        clear_i,
  output logic [CntWidth-1:0]         ce_count_o,
  output logic [CntWidth-1:0]         ue_count_o,
  output logic [AddrWidth-1:0]        last_ce_addr_o,
  output logic [AddrWidth-1:0]        first_ue_addr_o,
  output logic [6:0]                  first_ue_syndrome_o,
  output logic                        ue_valid_o,
  output logic                        overflow_o,
  output logic                        irq_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CE_SEEN   = 2'd1,
    UE_LOCKED = 2'd2
  } state_e;

  logic                 event_c;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_ue_q, s1_ue_d;
  logic [AddrWidth-1:0] s1_addr_q, s1_addr_d;
  logic [6:0]           s1_syn_q, s1_syn_d;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  ce_cnt_q, ce_cnt_d;
  logic [CntWidth-1:0]  ue_cnt_q, ue_cnt_d;
  logic [AddrWidth-1:0] last_ce_q, last_ce_d;
  logic [AddrWidth-1:0] first_ue_q, first_ue_d;
  logic [6:0]           first_syn_q, first_syn_d;
  logic                 ue_valid_q, ue_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q, irq_d;

  // Only granted writes carrying a decoder error are events.
  assign event_c = bus_i.req & bus_i.gnt & ~bus_i.wen & (bus_i.err != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_ue_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_syn_q    <= '0;
      state_q     <= IDLE;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
      last_ce_q   <= '0;
      first_ue_q  <= '0;
      first_syn_q <= '0;
      ue_valid_q  <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ue_q     <= s1_ue_d;
      s1_addr_q   <= s1_addr_d;
      s1_syn_q    <= s1_syn_d;
      state_q     <= state_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
      last_ce_q   <= last_ce_d;
      first_ue_q  <= first_ue_d;
      first_syn_q <= first_syn_d;
      ue_valid_q  <= ue_valid_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
    end
  end

  // Stage 1: register the event; payload is held when there is no event.
  always_comb begin
    s1_valid_d = event_c;
    s1_ue_d    = s1_ue_q;
    s1_addr_d  = s1_addr_q;
    s1_syn_d   = s1_syn_q;
    if (event_c) begin
      s1_ue_d   = bus_i.err[1];
      s1_addr_d = bus_i.add;
      s1_syn_d  = bus_i.syndrome;
    end
  end

  // Stage 2: clear is applied first, then any stage-1 event is folded in.
  always_comb begin
    state_d     = state_q;
    ce_cnt_d    = ce_cnt_q;
    ue_cnt_d    = ue_cnt_q;
    last_ce_d   = last_ce_q;
    first_ue_d  = first_ue_q;
    first_syn_d = first_syn_q;
    ue_valid_d  = ue_valid_q;
    ovf_d       = ovf_q;

    if (clear_i) begin
      state_d     = IDLE;
      ce_cnt_d    = '0;
      ue_cnt_d    = '0;
      last_ce_d   = '0;
      first_ue_d  = '0;
      first_syn_d = '0;
      ue_valid_d  = 1'b0;
      ovf_d       = 1'b0;
    end

    if (s1_valid_q) begin
      if (s1_ue_q) begin
        if (ue_cnt_d == '1) begin
          ovf_d = 1'b1;
        end else begin
          ue_cnt_d = ue_cnt_d + CntWidth'(1);
        end
        if (!ue_valid_d) begin
          first_ue_d  = s1_addr_q;
          first_syn_d = s1_syn_q;
          ue_valid_d  = 1'b1;
        end
        state_d = UE_LOCKED;
      end else begin
        if (ce_cnt_d == '1) begin
          ovf_d = 1'b1;
        end else begin
          ce_cnt_d = ce_cnt_d + CntWidth'(1);
        end
        last_ce_d = s1_addr_q;
        if (state_d == IDLE) begin
          state_d = CE_SEEN;
        end
      end
    end

    irq_d = (ue_cnt_d != '0) ||
            ((CeThreshold != 0) && (32'(ce_cnt_d) >= 32'(CeThreshold)));
  end

  assign ce_count_o          = ce_cnt_q;
  assign ue_count_o          = ue_cnt_q;
  assign last_ce_addr_o      = last_ce_q;
  assign first_ue_addr_o     = first_ue_q;
  assign first_ue_syndrome_o = first_syn_q;
  assign ue_valid_o          = ue_valid_q;
  assign overflow_o          = ovf_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_tcdm_ecc_err_logger.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_tcdm_ecc_err_logger;

  logic clk;
  logic rst_n;
  logic clr_a, clr_b;
  int   cyc = 0;
  int   now_c;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   next_id = 0;

  tcdm_ecc_err_logger_if #(.AddrWidth(32)) ifa ();
  tcdm_ecc_err_logger_if #(.AddrWidth(32)) ifb ();

  logic [15:0] a_ce, a_ue;
  logic [31:0] a_lce, a_fua;
  logic [6:0]  a_fus;
  logic        a_uv, a_ovf, a_irq;
  logic [3:0]  b_ce, b_ue;
  logic [31:0] b_lce, b_fua;
  logic [6:0]  b_fus;
  logic        b_uv, b_ovf, b_irq;

  tcdm_ecc_err_logger #(.AddrWidth(32), .CntWidth(16), .CeThreshold(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_i(ifa), .clear_i(clr_a),
    .ce_count_o(a_ce), .ue_count_o(a_ue), .last_ce_addr_o(a_lce),
    .first_ue_addr_o(a_fua), .first_ue_syndrome_o(a_fus), .ue_valid_o(a_uv),
    .overflow_o(a_ovf), .irq_o(a_irq)
  );

  tcdm_ecc_err_logger #(.AddrWidth(32), .CntWidth(4), .CeThreshold(8)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .bus_i(ifb), .clear_i(clr_b),
    .ce_count_o(b_ce), .ue_count_o(b_ue), .last_ce_addr_o(b_lce),
    .first_ue_addr_o(b_fua), .first_ue_syndrome_o(b_fus), .ue_valid_o(b_uv),
    .overflow_o(b_ovf), .irq_o(b_irq)
  );

  typedef struct {
    int          cyc;
    int          id;
    bit          sel;
    logic [15:0] ce, ue;
    logic [31:0] lce, fua;
    logic [6:0]  fus;
    logic        uv, ovf, irq;
  } exp_t;

  exp_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp(input bit sel, input int tgt, input int unsigned ce, input int unsigned ue,
                     input logic [31:0] lce, input logic [31:0] fua, input logic [6:0] fus,
                     input bit uv, input bit ovf, input bit irq);
    exp_t e;
    e.cyc = tgt; e.id = next_id; e.sel = sel;
    e.ce = 16'(ce); e.ue = 16'(ue); e.lce = lce; e.fua = fua; e.fus = fus;
    e.uv = uv; e.ovf = ovf; e.irq = irq;
    next_id++;
    q.push_back(e);
  endtask

  task automatic exp_zero(input bit sel, input int tgt);
    exp(sel, tgt, 0, 0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive one cycle on the selected bus; the other bus is idle.
  task automatic drv(input bit sel, input logic rq, input logic g, input logic w,
                     input logic [31:0] a, input logic [6:0] s, input logic [1:0] e,
                     input logic clr);
    @(posedge clk); #1;
    ifa.req = 1'b0; ifa.gnt = 1'b0; ifa.wen = 1'b1; ifa.add = '0; ifa.syndrome = '0; ifa.err = '0;
    ifb.req = 1'b0; ifb.gnt = 1'b0; ifb.wen = 1'b1; ifb.add = '0; ifb.syndrome = '0; ifb.err = '0;
    clr_a = 1'b0; clr_b = 1'b0;
    if (!sel) begin
      ifa.req = rq; ifa.gnt = g; ifa.wen = w; ifa.add = a; ifa.syndrome = s; ifa.err = e;
      clr_a = clr;
    end else begin
      ifb.req = rq; ifb.gnt = g; ifb.wen = w; ifb.add = a; ifb.syndrome = s; ifb.err = e;
      clr_b = clr;
    end
    now_c = cyc;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 2'b00, 1'b0);
  endtask

  task automatic ce_wr(input bit sel, input logic [31:0] a);
    drv(sel, 1'b1, 1'b1, 1'b0, a, 7'h0, 2'b01, 1'b0);
  endtask

  // Monitor: compare every expectation due this cycle; stale ones are failures.
  always @(negedge clk) begin
    int i;
    exp_t e;
    exp_t act;
    i = 0;
    while (i < q.size()) begin
      e = q[i];
      if (e.cyc == cyc) begin
        act = e;
        if (!e.sel) begin
          act.ce = a_ce; act.ue = a_ue; act.lce = a_lce; act.fua = a_fua; act.fus = a_fus;
          act.uv = a_uv; act.ovf = a_ovf; act.irq = a_irq;
        end else begin
          act.ce = 16'(b_ce); act.ue = 16'(b_ue); act.lce = b_lce; act.fua = b_fua;
          act.fus = b_fus; act.uv = b_uv; act.ovf = b_ovf; act.irq = b_irq;
        end
        total_cnt++;
        if (act.ce === e.ce && act.ue === e.ue && act.lce === e.lce && act.fua === e.fua &&
            act.fus === e.fus && act.uv === e.uv && act.ovf === e.ovf && act.irq === e.irq) begin
          pass_cnt++;
        end else begin
          $display("FAIL chk%0d dut%0d cyc%0d: got ce=%0d ue=%0d lce=%h fua=%h fus=%h uv=%b ovf=%b irq=%b, want ce=%0d ue=%0d lce=%h fua=%h fus=%h uv=%b ovf=%b irq=%b",
                   e.id, e.sel, cyc, act.ce, act.ue, act.lce, act.fua, act.fus, act.uv, act.ovf, act.irq,
                   e.ce, e.ue, e.lce, e.fua, e.fus, e.uv, e.ovf, e.irq);
        end
        q.delete(i);
      end else if (e.cyc < cyc) begin
        total_cnt++;
        $display("FAIL chk%0d expired: due cyc%0d, now cyc%0d", e.id, e.cyc, cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int c;
    int n;
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.req = 1'b0; ifa.gnt = 1'b0; ifa.wen = 1'b1; ifa.add = '0; ifa.syndrome = '0; ifa.err = '0;
    ifb.req = 1'b0; ifb.gnt = 1'b0; ifb.wen = 1'b1; ifb.add = '0; ifb.syndrome = '0; ifb.err = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    c = cyc;
    exp_zero(1'b0, c + 1);
    exp_zero(1'b1, c + 1);
    exp_zero(1'b0, c + 2);
    idle(); idle();

    // Three CEs, then a read and a non-granted write that must be ignored.
    for (int i = 0; i < 3; i++) begin
      ce_wr(1'b0, 32'h100 + 32'(4 * i));
      exp(1'b0, now_c + 2, i + 1, 0, 32'h100 + 32'(4 * i), 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    end
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 7'h0, 2'b01, 1'b0);
    exp(1'b0, now_c + 2, 3, 0, 32'h108, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 7'h0, 2'b01, 1'b0);
    exp(1'b0, now_c + 2, 3, 0, 32'h108, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);

    // Five more CEs; irq rises with the eighth.
    for (int i = 3; i < 8; i++) begin
      ce_wr(1'b0, 32'h100 + 32'(4 * i));
      exp(1'b0, now_c + 2, i + 1, 0, 32'h100 + 32'(4 * i), 32'h0, 7'h0, 1'b0, 1'b0, (i + 1) >= 8);
    end
    idle(); idle();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 2'b00, 1'b1);
    exp_zero(1'b0, now_c + 1);
    exp_zero(1'b0, now_c + 2);

    // Two UEs (second is 2'b11) and a CE while UE-locked.
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 7'h15, 2'b10, 1'b0);
    exp(1'b0, now_c + 2, 0, 1, 32'h0, 32'h200, 7'h15, 1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 7'h2A, 2'b11, 1'b0);
    exp(1'b0, now_c + 2, 0, 2, 32'h0, 32'h200, 7'h15, 1'b1, 1'b0, 1'b1);
    ce_wr(1'b0, 32'h400);
    exp(1'b0, now_c + 2, 1, 2, 32'h400, 32'h200, 7'h15, 1'b1, 1'b0, 1'b1);
    idle(); idle();

    // UE in cycle N, clear in N+1: clear first, then the UE is applied.
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 7'h33, 2'b10, 1'b0);
    c = now_c;
    exp(1'b0, c + 2, 0, 1, 32'h0, 32'h300, 7'h33, 1'b1, 1'b0, 1'b1);
    exp(1'b0, c + 3, 0, 1, 32'h0, 32'h300, 7'h33, 1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 2'b00, 1'b1);
    idle(); idle();

    // CE arriving in the same cycle as clear enters stage 1 normally.
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 7'h0, 2'b01, 1'b1);
    exp_zero(1'b0, now_c + 1);
    exp(1'b0, now_c + 2, 1, 0, 32'h500, 32'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // Reset while a CE sits in stage 1 discards it.
    ce_wr(1'b0, 32'h600);
    c = now_c;
    idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    exp_zero(1'b0, c + 2);
    exp_zero(1'b0, c + 3);
    idle(); idle();

    // 4-bit counter: 17 back-to-back CEs saturate at 15 and set overflow.
    for (int i = 0; i < 17; i++) begin
      ce_wr(1'b1, 32'h1000 + 32'(4 * i));
      n = i + 1;
      exp(1'b1, now_c + 2, (n > 15) ? 15 : n, 0, 32'h1000 + 32'(4 * i), 32'h0, 7'h0,
          1'b0, n > 15, n >= 8);
    end
    idle(); idle();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 2'b00, 1'b1);
    exp_zero(1'b1, now_c + 1);
    exp_zero(1'b1, now_c + 2);
    idle();

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked", q.size());
      total_cnt += q.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
